// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: reverse-Polish expression controller driving an external
// 8-bit push/pop stack. It tracks stack occupancy locally because the stack
// exposes no full/empty flags. Results of EQ are emitted on a valid/ready port.
module rpn_stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tok_valid,
    output logic                       tok_ready,
    input  logic                       tok_is_op,
    input  logic [WIDTH-1:0]           tok_data,
    output logic                       stk_push,
    output logic [WIDTH-1:0]           stk_din,
    output logic                       stk_pop,
    input  logic [WIDTH-1:0]           stk_dout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic                       err,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH+1)-1:0] depth
);

    localparam int DW = $clog2(DEPTH+1);
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);
    localparam logic [DW-1:0] ONE     = DW'(1);
    localparam logic [DW-1:0] TWO     = DW'(2);

    typedef enum logic [2:0] {IDLE, PUSH, POPB, POPA, POPR, EMIT, ERR, DRAIN} state_t;

    state_t           state;
    logic [1:0]       op_q;    // binary opcode latched at accept (ADD/SUB/AND/OR)
    logic [WIDTH-1:0] b_q;     // right operand, i.e. the later-pushed value
    logic [WIDTH-1:0] alu_res;
    logic             tok_acc;

    // Tokens are taken only from a clean IDLE; held low while reset is asserted.
    assign tok_ready = (state == IDLE) && !err && !rst;
    assign tok_acc   = tok_valid && tok_ready;

    // Binary operator result: stack top during POPA is the earlier-pushed operand a.
    always_comb begin
        alu_res = '0;
        case (op_q)
            2'd0: alu_res = stk_dout + b_q;
            2'd1: alu_res = stk_dout - b_q;
            2'd2: alu_res = stk_dout & b_q;
            2'd3: alu_res = stk_dout | b_q;
            default: alu_res = '0;
        endcase
    end

    // Controller FSM; strobes and result outputs are registered on state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            depth     <= '0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_din   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
            op_q      <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tok_acc) begin
                        if (!tok_is_op) begin
                            if (depth == DEPTH_V) begin
                                state <= ERR;
                                err   <= 1'b1;
                            end else begin
                                state    <= PUSH;
                                stk_push <= 1'b1;
                                stk_din  <= tok_data;
                            end
                        end else if (tok_data <= WIDTH'(3)) begin
                            if (depth >= TWO) begin
                                state   <= POPB;
                                stk_pop <= 1'b1;
                                op_q    <= tok_data[1:0];
                            end else begin
                                state <= ERR;
                                err   <= 1'b1;
                            end
                        end else if (tok_data == WIDTH'(4)) begin
                            if (depth >= ONE) begin
                                state   <= POPR;
                                stk_pop <= 1'b1;
                            end else begin
                                state <= ERR;
                                err   <= 1'b1;
                            end
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                PUSH: begin
                    stk_push <= 1'b0;
                    depth    <= depth + ONE;
                    state    <= IDLE;
                end
                POPB: begin
                    b_q   <= stk_dout;
                    depth <= depth - ONE;
                    state <= POPA;
                end
                POPA: begin
                    stk_pop  <= 1'b0;
                    depth    <= depth - ONE;
                    stk_push <= 1'b1;
                    stk_din  <= alu_res;
                    state    <= PUSH;
                end
                POPR: begin
                    stk_pop   <= 1'b0;
                    depth     <= depth - ONE;
                    res_data  <= stk_dout;
                    res_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        state   <= DRAIN;
                        stk_pop <= (depth != '0);
                    end
                end
                DRAIN: begin
                    if (depth != '0) begin
                        depth   <= depth - ONE;
                        stk_pop <= (depth > ONE);
                    end else begin
                        stk_pop <= 1'b0;
                        err     <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: behavioural stack on the stack port, directed
// scenarios, and a randomized token stream checked against a queue-based
// RPN evaluator.
module tb_rpn_stack_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tok_valid = 1'b0;
    logic             tok_ready;
    logic             tok_is_op = 1'b0;
    logic [WIDTH-1:0] tok_data = '0;
    logic             stk_push;
    logic [WIDTH-1:0] stk_din;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_dout;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH-1:0] res_data;
    logic             err;
    logic             err_clr = 1'b0;
    logic [3:0]       depth;

    int n_pass = 0;
    int n_total = 0;

    rpn_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
        .stk_push(stk_push), .stk_din(stk_din), .stk_pop(stk_pop), .stk_dout(stk_dout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err(err), .err_clr(err_clr), .depth(depth)
    );

    always #5 clk = ~clk;

    // Behavioural stack sharing the controller's reset.
    logic [WIDTH-1:0] mem [0:31];
    logic [4:0]       sp;
    assign stk_dout = (sp != 5'd0) ? mem[sp - 5'd1] : '0;

    always @(posedge clk or posedge rst) begin
        if (rst) sp <= 5'd0;
        else if (stk_push) begin
            mem[sp] <= stk_din;
            sp      <= sp + 5'd1;
        end else if (stk_pop && sp != 5'd0) sp <= sp - 5'd1;
    end

    // Strobe monitor: logs pushed/popped values and illegal strobe patterns.
    logic [WIDTH-1:0] push_log[$];
    logic [WIDTH-1:0] pop_log[$];
    int  bad_strobe = 0;
    logic prev_push = 1'b0;
    always @(posedge clk) begin
        if (!rst) begin
            if (stk_push) push_log.push_back(stk_din);
            if (stk_pop)  pop_log.push_back(stk_dout);
            if ((stk_push && stk_pop) || (stk_push && prev_push)) bad_strobe <= bad_strobe + 1;
            prev_push <= stk_push;
        end else prev_push <= 1'b0;
    end

    // Send one token and let the controller settle (IDLE, ERR); captures any result.
    task automatic run_tok(input logic is_op, input logic [7:0] d,
                           output logic got, output logic [7:0] rv);
        int n;
        got = 1'b0; rv = '0; n = 0;
        @(negedge clk);
        while (!tok_ready && n < 50) begin @(negedge clk); n++; end
        if (!tok_ready) begin
            n_total++;
            $display("FAIL tok_wait: tok_ready stayed %0b, required 1", tok_ready);
            return;
        end
        tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
        @(posedge clk); #1 tok_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (res_valid) begin got = 1'b1; rv = res_data; end
            n++;
        end while (!(tok_ready || err) && n < 50);
        if (n >= 50) begin
            n_total++;
            $display("FAIL settle: controller did not settle, err=%0b tok_ready=%0b", err, tok_ready);
        end
    endtask

    task automatic clear_logs();
        push_log.delete();
        pop_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({tok_ready, stk_push, stk_pop, res_valid, err, stk_din, res_data, depth} !== '0)
            $display("FAIL reset_outputs: got rdy=%0b push=%0b pop=%0b rv=%0b err=%0b din=%h rd=%h dep=%0d, required all 0",
                     tok_ready, stk_push, stk_pop, res_valid, err, stk_din, res_data, depth);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (tok_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b required 1", tok_ready);
        else n_pass++;
    endtask

    task automatic test_add();
        logic g; logic [7:0] r;
        clear_logs();
        run_tok(1'b0, 8'd7, g, r);
        run_tok(1'b0, 8'd5, g, r);
        n_total++;
        if (depth !== 4'd2) $display("FAIL add_depth2: got %0d required 2", depth); else n_pass++;
        run_tok(1'b1, 8'd0, g, r);
        n_total++;
        if (push_log.size() != 3 || push_log[0] !== 8'd7 || push_log[1] !== 8'd5 || push_log[2] !== 8'd12)
            $display("FAIL add_pushes: got %p required 7,5,12", push_log);
        else n_pass++;
        n_total++;
        if (pop_log.size() != 2 || pop_log[0] !== 8'd5 || pop_log[1] !== 8'd7)
            $display("FAIL add_pops: got %p required 5,7", pop_log);
        else n_pass++;
        run_tok(1'b1, 8'd4, g, r);
        n_total++;
        if (!g || r !== 8'd12) $display("FAIL add_result: got valid=%0b data=%0d required 12", g, r);
        else n_pass++;
        n_total++;
        if (depth !== 4'd0 || pop_log.size() != 3 || pop_log[2] !== 8'd12)
            $display("FAIL add_final: got depth=%0d pops=%0d required depth 0, 3 pops", depth, pop_log.size());
        else n_pass++;
    endtask

    task automatic test_sub_wrap();
        logic g; logic [7:0] r;
        run_tok(1'b0, 8'd3, g, r);
        run_tok(1'b0, 8'd5, g, r);
        run_tok(1'b1, 8'd1, g, r);
        run_tok(1'b1, 8'd4, g, r);
        n_total++;
        if (!g || r !== 8'hFE) $display("FAIL sub_result: got valid=%0b data=%h required fe", g, r);
        else n_pass++;
        run_tok(1'b0, 8'hF0, g, r);
        run_tok(1'b0, 8'h20, g, r);
        run_tok(1'b1, 8'd0, g, r);
        run_tok(1'b1, 8'd4, g, r);
        n_total++;
        if (!g || r !== 8'h10) $display("FAIL add_wrap: got valid=%0b data=%h required 10", g, r);
        else n_pass++;
    endtask

    task automatic test_underflow();
        logic g; logic [7:0] r; int n;
        clear_logs();
        run_tok(1'b0, 8'd9, g, r);
        run_tok(1'b1, 8'd0, g, r);
        n_total++;
        if (err !== 1'b1 || tok_ready !== 1'b0 || pop_log.size() != 0)
            $display("FAIL underflow_err: got err=%0b rdy=%0b pops=%0d required 1,0,0", err, tok_ready, pop_log.size());
        else n_pass++;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        n = 0;
        while (!tok_ready && n < 30) begin @(negedge clk); n++; end
        n_total++;
        if (pop_log.size() != 1 || depth !== 4'd0 || err !== 1'b0 || tok_ready !== 1'b1)
            $display("FAIL underflow_drain: got pops=%0d depth=%0d err=%0b rdy=%0b required 1,0,0,1",
                     pop_log.size(), depth, err, tok_ready);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic g; logic [7:0] r; int n;
        clear_logs();
        for (int i = 0; i < DEPTH; i++) run_tok(1'b0, 8'($urandom), g, r);
        n_total++;
        if (depth !== 4'(DEPTH) || err !== 1'b0) $display("FAIL full_depth: got %0d err=%0b required %0d", depth, err, DEPTH);
        else n_pass++;
        run_tok(1'b0, 8'hAA, g, r);
        n_total++;
        if (err !== 1'b1 || depth !== 4'(DEPTH) || push_log.size() != DEPTH)
            $display("FAIL overflow_err: got err=%0b depth=%0d pushes=%0d required 1,%0d,%0d",
                     err, depth, push_log.size(), DEPTH, DEPTH);
        else n_pass++;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        n = 0;
        while (!tok_ready && n < 40) begin @(negedge clk); n++; end
        n_total++;
        if (pop_log.size() != DEPTH || depth !== 4'd0 || err !== 1'b0 || tok_ready !== 1'b1)
            $display("FAIL overflow_drain: got pops=%0d depth=%0d err=%0b required %0d,0,0",
                     pop_log.size(), depth, err, DEPTH);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic g; logic [7:0] r; int n;
        run_tok(1'b0, 8'h33, g, r);
        res_ready = 1'b0;
        @(negedge clk);
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd4;
        @(posedge clk); #1 tok_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 10);
        n_total++;
        if (res_valid !== 1'b1 || res_data !== 8'h33)
            $display("FAIL bp_first: got valid=%0b data=%h required 1,33", res_valid, res_data);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (res_valid !== 1'b1 || res_data !== 8'h33 || tok_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got valid=%0b data=%h rdy=%0b required 1,33,0", i, res_valid, res_data, tok_ready);
            else n_pass++;
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (res_valid !== 1'b0 || tok_ready !== 1'b1 || depth !== 4'd0)
            $display("FAIL bp_done: got valid=%0b rdy=%0b depth=%0d required 0,1,0", res_valid, tok_ready, depth);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        logic g; logic [7:0] r;
        run_tok(1'b0, 8'd1, g, r);
        run_tok(1'b0, 8'd2, g, r);
        @(negedge clk);
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd0;
        @(posedge clk); #1 tok_valid = 1'b0;
        @(negedge clk);   // POPB
        @(negedge clk);   // POPA
        n_total++;
        if (stk_pop !== 1'b1 || depth !== 4'd1) $display("FAIL popa_state: got pop=%0b depth=%0d required 1,1", stk_pop, depth);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({tok_ready, stk_push, stk_pop, res_valid, err, stk_din, res_data, depth} !== '0)
            $display("FAIL midreset_outputs: got rdy=%0b push=%0b pop=%0b rv=%0b err=%0b din=%h rd=%h dep=%0d, required all 0",
                     tok_ready, stk_push, stk_pop, res_valid, err, stk_din, res_data, depth);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        run_tok(1'b0, 8'd2, g, r);
        run_tok(1'b0, 8'd2, g, r);
        run_tok(1'b1, 8'd3, g, r);
        run_tok(1'b1, 8'd4, g, r);
        n_total++;
        if (!g || r !== 8'd2 || depth !== 4'd0) $display("FAIL after_reset_or: got valid=%0b data=%0d depth=%0d required 2", g, r, depth);
        else n_pass++;
    endtask

    // Random token stream against a queue-based RPN evaluator.
    task automatic test_random();
        logic [7:0] mdl[$];
        logic g; logic [7:0] r, a, b, v, exp_r;
        logic is_op, exp_err, exp_res;
        int pops_before, n;
        for (int t = 0; t < 150; t++) begin
            is_op = ($urandom_range(0, 9) < 4);
            v = is_op ? 8'($urandom_range(0, 5)) : 8'($urandom);
            exp_err = 1'b0; exp_res = 1'b0; exp_r = '0;
            if (!is_op) begin
                if (mdl.size() == DEPTH) exp_err = 1'b1; else mdl.push_back(v);
            end else if (v <= 8'd3) begin
                if (mdl.size() < 2) exp_err = 1'b1;
                else begin
                    b = mdl.pop_back(); a = mdl.pop_back();
                    case (v)
                        8'd0: mdl.push_back(8'((int'(a) + int'(b)) % 256));
                        8'd1: mdl.push_back(8'((int'(a) - int'(b) + 256) % 256));
                        8'd2: mdl.push_back(a & b);
                        default: mdl.push_back(a | b);
                    endcase
                end
            end else if (v == 8'd4) begin
                if (mdl.size() < 1) exp_err = 1'b1;
                else begin exp_res = 1'b1; exp_r = mdl.pop_back(); end
            end else exp_err = 1'b1;
            run_tok(is_op, v, g, r);
            n_total++;
            if (err !== exp_err || depth !== 4'(mdl.size()) || g !== exp_res || (exp_res && r !== exp_r))
                $display("FAIL rand_tok%0d: got err=%0b depth=%0d res=%0b/%h required err=%0b depth=%0d res=%0b/%h",
                         t, err, depth, g, r, exp_err, mdl.size(), exp_res, exp_r);
            else n_pass++;
            if (err) begin
                pops_before = pop_log.size();
                err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
                n = 0;
                while (!tok_ready && n < 40) begin @(negedge clk); n++; end
                n_total++;
                if (pop_log.size() - pops_before != mdl.size() || depth !== 4'd0 || err !== 1'b0)
                    $display("FAIL rand_drain%0d: got pops=%0d depth=%0d err=%0b required %0d,0,0",
                             t, pop_log.size() - pops_before, depth, err, mdl.size());
                else n_pass++;
                mdl.delete();
            end
        end
    endtask

    task automatic test_strobes();
        n_total++;
        if (bad_strobe != 0) $display("FAIL strobe_rules: got %0d violations required 0", bad_strobe);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_underflow();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_strobes();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
